// File: rtl/vend_ctrl_param.sv
// Coin-credit vending controller: accumulates credit against a configurable price,
// pulses a dispense strobe, and returns overpayment or refunds through a valid/ack handshake.
module vend_ctrl_param #(
  parameter int WIDTH      = 8,
  parameter int PRICE      = 80,
  parameter int MAX_CREDIT = 150,
  parameter int COIN1      = 10,
  parameter int COIN2      = 25,
  parameter int COIN3      = 50,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_sel,
  input  logic             i_coin_valid,
  input  logic             i_cancel,
  input  logic             i_change_ack,
  output logic [WIDTH-1:0] o_total,
  output logic             o_release,
  output logic [WIDTH-1:0] o_change,
  output logic             o_change_valid,
  output logic             o_coin_reject,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_vend_count
);

  localparam logic [1:0] S_ACCUM  = 2'd0;
  localparam logic [1:0] S_VEND   = 2'd1;
  localparam logic [1:0] S_CHANGE = 2'd2;

  localparam logic [WIDTH-1:0] LP_COIN1   = WIDTH'(COIN1);
  localparam logic [WIDTH-1:0] LP_COIN2   = WIDTH'(COIN2);
  localparam logic [WIDTH-1:0] LP_COIN3   = WIDTH'(COIN3);
  localparam logic [WIDTH-1:0] LP_PRICE   = WIDTH'(PRICE);
  localparam logic [WIDTH:0]   LP_PRICE_X = (WIDTH+1)'(PRICE);
  localparam logic [WIDTH:0]   LP_MAX_X   = (WIDTH+1)'(MAX_CREDIT);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_total;
  logic [WIDTH-1:0] r_change;
  logic             r_coin_reject;
  logic [CNT_W-1:0] r_vend_count;

  logic [WIDTH-1:0] w_coin_val;
  logic             w_coin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_excess;

  always_comb begin
    case (i_sel)
      2'd1:    w_coin_val = LP_COIN1;
      2'd2:    w_coin_val = LP_COIN2;
      2'd3:    w_coin_val = LP_COIN3;
      default: w_coin_val = '0;
    endcase
  end

  // A strobe with sel=0 carries no coin: neither credited nor rejected.
  assign w_coin   = i_coin_valid && (i_sel != 2'd0);
  // One extra bit so an overflowing coin is detected rather than wrapped.
  assign w_sum    = {1'b0, r_total} + {1'b0, w_coin_val};
  assign w_excess = r_total - LP_PRICE;

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_ACCUM;
      r_total       <= '0;
      r_change      <= '0;
      r_coin_reject <= 1'b0;
      r_vend_count  <= '0;
    end else begin
      r_coin_reject <= 1'b0;
      case (r_state)
        S_ACCUM: begin
          if (i_cancel) begin
            r_coin_reject <= w_coin;
            if (r_total != '0) begin
              r_change <= r_total;
              r_total  <= '0;
              r_state  <= S_CHANGE;
            end
          end else if (w_coin) begin
            if (w_sum > LP_MAX_X) begin
              r_coin_reject <= 1'b1;
            end else begin
              r_total <= w_sum[WIDTH-1:0];
              if (w_sum >= LP_PRICE_X) r_state <= S_VEND;
            end
          end
        end
        S_VEND: begin
          r_coin_reject <= w_coin;
          r_change      <= w_excess;
          r_total       <= '0;
          r_vend_count  <= r_vend_count + 1'b1;
          r_state       <= (w_excess != '0) ? S_CHANGE : S_ACCUM;
        end
        S_CHANGE: begin
          r_coin_reject <= w_coin;
          if (i_change_ack) begin
            r_change <= '0;
            r_state  <= S_ACCUM;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  assign o_total        = r_total;
  assign o_change       = r_change;
  assign o_coin_reject  = r_coin_reject;
  assign o_vend_count   = r_vend_count;
  assign o_release      = (r_state == S_VEND);
  assign o_busy         = (r_state != S_ACCUM);
  assign o_change_valid = (r_state == S_CHANGE);

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: a default instance plus a PRICE=MAX_CREDIT=100,
// 2-bit-counter instance sharing the same stimulus.
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       coin_valid, cancel, change_ack;

  logic [7:0]  a_total, a_change;
  logic        a_release, a_change_valid, a_coin_reject, a_busy;
  logic [15:0] a_vend_count;

  logic [7:0]  b_total, b_change;
  logic        b_release, b_change_valid, b_coin_reject, b_busy;
  logic [1:0]  b_vend_count;

  int total_n = 0;
  int bad_n   = 0;

  always #5 clk = ~clk;

  vend_ctrl_param dut_a (
    .clk(clk), .rst(rst), .i_sel(sel), .i_coin_valid(coin_valid),
    .i_cancel(cancel), .i_change_ack(change_ack),
    .o_total(a_total), .o_release(a_release), .o_change(a_change),
    .o_change_valid(a_change_valid), .o_coin_reject(a_coin_reject),
    .o_busy(a_busy), .o_vend_count(a_vend_count)
  );

  vend_ctrl_param #(.PRICE(100), .MAX_CREDIT(100), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .i_sel(sel), .i_coin_valid(coin_valid),
    .i_cancel(cancel), .i_change_ack(change_ack),
    .o_total(b_total), .o_release(b_release), .o_change(b_change),
    .o_change_valid(b_change_valid), .o_coin_reject(b_coin_reject),
    .o_busy(b_busy), .o_vend_count(b_vend_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] s);
    sel = s; coin_valid = 1'b1;
    tick();
    sel = 2'd0; coin_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic ack();
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; coin_valid = 1'b0; cancel = 1'b0; change_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_total", a_total, 0);
    check("rst_release", a_release, 0);
    check("rst_change", a_change, 0);
    check("rst_cvalid", a_change_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_count", a_vend_count, 0);

    // Overpay: 50, 25, 10 -> 85, change 5.
    coin(2'd3); check("t1_total50", a_total, 50);
    coin(2'd2); check("t1_total75", a_total, 75); check("t1_norel", a_release, 0);
    coin(2'd1); check("t1_total85", a_total, 85); check("t1_release", a_release, 1);
    check("t1_busy_vend", a_busy, 1);
    tick();
    check("t1_rel_low", a_release, 0); check("t1_cvalid", a_change_valid, 1);
    check("t1_change", a_change, 5); check("t1_total0", a_total, 0);
    check("t1_count", a_vend_count, 1);
    tick();
    check("t1_hold_cv", a_change_valid, 1); check("t1_hold_ch", a_change, 5);
    ack();
    check("t1_ack_cv", a_change_valid, 0); check("t1_ack_ch", a_change, 0);
    check("t1_ack_busy", a_busy, 0);

    // Exact price: 50, 10, 10, 10 -> 80, no change.
    coin(2'd3); coin(2'd1); coin(2'd1);
    check("t2_total70", a_total, 70);
    coin(2'd1); check("t2_total80", a_total, 80); check("t2_release", a_release, 1);
    tick();
    check("t2_no_cv", a_change_valid, 0); check("t2_busy", a_busy, 0);
    check("t2_count", a_vend_count, 2); check("t2_total0", a_total, 0);

    // Cancel refund: 25, 25, 10 -> 60 refunded.
    coin(2'd2); coin(2'd2); coin(2'd1);
    check("t3_total60", a_total, 60);
    do_cancel();
    check("t3_change", a_change, 60); check("t3_cv", a_change_valid, 1);
    check("t3_rel", a_release, 0); check("t3_total0", a_total, 0);
    check("t3_count", a_vend_count, 2);
    ack();
    check("t3_ack_cv", a_change_valid, 0); check("t3_ack_total", a_total, 0);

    // Cancel with zero credit and a sel=0 strobe are both ignored.
    do_cancel();
    check("t5_cancel0_cv", a_change_valid, 0); check("t5_cancel0_busy", a_busy, 0);
    coin(2'd0);
    check("t5_sel0_rej", a_coin_reject, 0); check("t5_sel0_total", a_total, 0);

    // Coin during CHANGE is rejected; change holds 20.
    coin(2'd3); coin(2'd3); check("t5_release", a_release, 1);
    tick(); check("t5_change20", a_change, 20);
    coin(2'd1);
    check("t5_rej", a_coin_reject, 1); check("t5_change_hold", a_change, 20);
    check("t5_total_hold", a_total, 0);
    tick(); check("t5_rej_low", a_coin_reject, 0);
    ack();

    // Coin and cancel together at credit 30: refund 30, coin rejected.
    coin(2'd1); coin(2'd1); coin(2'd1);
    check("t5_total30", a_total, 30);
    sel = 2'd1; coin_valid = 1'b1; cancel = 1'b1;
    tick();
    sel = 2'd0; coin_valid = 1'b0; cancel = 1'b0;
    check("t5_refund", a_change, 30); check("t5_refund_cv", a_change_valid, 1);
    check("t5_both_rej", a_coin_reject, 1); check("t5_both_total", a_total, 0);
    ack();

    // Reset mid-CHANGE with change 45: 50, 25, 50 -> 125.
    coin(2'd3); coin(2'd2); coin(2'd3);
    check("t6_release", a_release, 1);
    tick(); check("t6_change45", a_change, 45); check("t6_cv", a_change_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_change", a_change, 0); check("t6_rst_cv", a_change_valid, 0);
    check("t6_rst_busy", a_busy, 0); check("t6_rst_total", a_total, 0);
    check("t6_rst_count", a_vend_count, 0); check("t6_rst_rel", a_release, 0);
    check("t6_rst_rej", a_coin_reject, 0);

    // Ceiling: PRICE=MAX_CREDIT=100; 50, 25, 50 -> third rejected.
    coin(2'd3); coin(2'd2);
    check("t4_total75", b_total, 75);
    coin(2'd3);
    check("t4_rej", b_coin_reject, 1); check("t4_total_hold", b_total, 75);
    check("t4_norel", b_release, 0);
    coin(2'd2);
    check("t4_rej_low", b_coin_reject, 0); check("t4_total100", b_total, 100);
    check("t4_release", b_release, 1);
    tick();
    check("t4_no_cv", b_change_valid, 0); check("t4_count1", b_vend_count, 1);

    // 2-bit vend counter wraps after the fourth vend.
    for (int i = 0; i < 3; i++) begin
      coin(2'd3); coin(2'd3); tick();
    end
    check("t6_wrap", b_vend_count, 0); check("t6_wrap_busy", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
Parametrised successor to the single-price candy machine. It accumulates coin credit against a configurable price and asserts a one-cycle release. It returns the overpayment as change through a valid/ack handshake, supports a cancel/refund, rejects coins that would overflow a credit ceiling, and counts completed vends. It sits between the coin-acceptor front end (one strobe per coin) and the dispenser/change-hopper drivers.

Parameters:
WIDTH, 8, bit width of credit, total and change
PRICE, 80, product price in credit units; must satisfy 0 < PRICE <= MAX_CREDIT
MAX_CREDIT, 150, highest credit ever held; must be < 2**WIDTH
COIN1, 10, credit value for sel=1
COIN2, 25, credit value for sel=2
COIN3, 50, credit value for sel=3
CNT_W, 16, width of vend_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
sel  input  2  coin type: 0 = no coin, 1..3 = COIN1..COIN3; sampled only with coin_valid
coin_valid  input  1  one-cycle strobe, one coin per strobe
cancel  input  1  refund request, sampled each cycle
change_ack  input  1  hopper has taken the change value
total  output  WIDTH  current accumulated credit, registered
release  output  1  one-cycle dispense pulse
change  output  WIDTH  change/refund amount, stable while change_valid
change_valid  output  1  change pending
coin_reject  output  1  one-cycle pulse: the coin strobed last cycle was not credited (return it)
busy  output  1  high in VEND or CHANGE state
vend_count  output  CNT_W  completed vends, wraps to 0 after all-ones

Behaviour:
- Reset: the clock and reset are decided as one clock, clk; reset rst is synchronous and active-high. Reset forces state ACCUM and clears every output to 0: total, release, change, change_valid, coin_reject, busy and vend_count. Reset wins over all other inputs in every state, including mid-CHANGE, where pending change is discarded.
- States: ACCUM, VEND, CHANGE. Moore outputs: release = (state==VEND); busy = (state!=ACCUM); change_valid = (state==CHANGE).
- coin value v: sel 0 gives 0; otherwise COINn. A strobe with sel=0 is ignored, with no credit and no reject.
- ACCUM, cancel=1:
  - If total>0: change<=total, total<=0, go to CHANGE.
  - If total==0: cancel is ignored.
  - Any coin strobed in the same cycle is rejected.
- ACCUM, coin_valid with v>0 and no cancel:
  - Compute sum=total+v at WIDTH+1 bits.
  - If sum>MAX_CREDIT: reject, total unchanged.
  - Else total<=sum, and go to VEND if sum>=PRICE.
- VEND: exactly one cycle.
  - On exit: change<=total-PRICE, total<=0, vend_count<=vend_count+1.
  - Next state is CHANGE if total-PRICE>0, else ACCUM.
- CHANGE: change held constant.
  - On change_ack: change<=0, go to ACCUM.
  - change_ack outside CHANGE is ignored.
- Coins strobed in VEND or CHANGE are rejected. cancel in VEND or CHANGE is ignored.
- coin_reject is registered: high in the cycle after the rejected strobe, for one cycle per rejected coin.
- Latency:
  - A credited coin appears on total one cycle after its strobe.
  - release is high in the cycle after the edge that crossed PRICE.
  - change_valid rises the cycle after release.
- Back-to-back strobes on consecutive cycles are each evaluated against the already-updated total.

Test Plan:
- Defaults; coins 50, 25, 10 on consecutive cycles -> total 50, 75, 85; release 1 cycle; then change=5 with change_valid until ack; vend_count=1; total=0.
- Coins 50, 10, 10, 10 -> total reaches 80, release pulses, change_valid never asserts, returns to ACCUM; vend_count=1.
- Coins 25, 25, 10 then cancel -> change=60, change_valid=1, release never pulses, vend_count unchanged; change_ack -> ACCUM with total 0.
- MAX_CREDIT=100, PRICE=100: coins 50, 25, then 50 -> third coin rejected (coin_reject pulse), total stays 75; coin 25 -> release, change never asserts.
- During CHANGE (change=20), strobe a coin -> coin_reject pulses and change stays 20. In ACCUM, coin and cancel in the same cycle (total 30) -> refund 30 and the coin is rejected.
- Assert rst while change_valid=1 with change=45 -> next cycle all outputs 0, state ACCUM. vend_count preset near all-ones via repeated vends wraps to 0.
